// File: rtl/sega_joy_pkg.sv
// Shared types and bit positions for the Sega joystick sequencer.
package sega_joy_pkg;

  // Sequencer phases: idle gap, then six alternating select phases
  typedef enum logic [2:0] {StGap, StP0, StP1, StP2, StP3, StP4, StP5} phase_e;

  // Button vector bit positions, MXYZ SACB RLDU order
  localparam int unsigned JOY_U = 0;
  localparam int unsigned JOY_D = 1;
  localparam int unsigned JOY_L = 2;
  localparam int unsigned JOY_R = 3;
  localparam int unsigned JOY_B = 4;
  localparam int unsigned JOY_C = 5;
  localparam int unsigned JOY_A = 6;
  localparam int unsigned JOY_S = 7;
  localparam int unsigned JOY_Z = 8;
  localparam int unsigned JOY_Y = 9;
  localparam int unsigned JOY_X = 10;
  localparam int unsigned JOY_M = 11;

  // Raw DB9 pin positions within the 6-bit input vector
  localparam int unsigned PIN_U  = 0;
  localparam int unsigned PIN_D  = 1;
  localparam int unsigned PIN_L  = 2;
  localparam int unsigned PIN_R  = 3;
  localparam int unsigned PIN_P6 = 4;
  localparam int unsigned PIN_P9 = 5;

  localparam logic [11:0] JOY_IDLE = 12'hFFF;

  // Select line level driven during a phase
  function automatic logic phase_sel(phase_e ph);
    case (ph)
      StP0, StP2, StP4: return 1'b0;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sega_joy_port.sv
// One joystick port: input synchroniser, per-frame shadow capture, pad-type
// detection and the atomically updated output register.
module sega_joy_port
  import sega_joy_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  pins_i,
  input  phase_e      phase_i,
  input  logic        last_i,
  output logic [11:0] joy_o,
  output logic        six_o
);

  logic [5:0]  sync1_q, sync2_q;
  logic [11:0] shadow_q, shadow_d;
  logic        md_q, md_d;
  logic        six_q, six_d;
  logic [11:0] joy_q, joy_d;
  logic        six_out_q, six_out_d;
  logic [3:0]  dirs;
  logic [1:0]  hi;

  // Two-flop synchroniser; idle level is all pins released
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
    end
  end

  assign dirs = sync2_q[PIN_R:PIN_U];
  assign hi   = {sync2_q[PIN_P9], sync2_q[PIN_P6]};

  // Capture pins on the last cycle of each sampling phase
  always_comb begin
    shadow_d  = shadow_q;
    md_d      = md_q;
    six_d     = six_q;
    joy_d     = joy_q;
    six_out_d = six_out_q;
    if (last_i) begin
      case (phase_i)
        // Leaving the gap: start the frame from a clean slate
        StGap: begin
          shadow_d = JOY_IDLE;
          md_d     = 1'b0;
          six_d    = 1'b0;
        end
        StP1: begin
          shadow_d[JOY_R:JOY_U] = dirs;
          shadow_d[JOY_C:JOY_B] = hi;
        end
        // L and R both low with select low identifies a Mega Drive pad
        StP2: begin
          if (!dirs[PIN_L] && !dirs[PIN_R]) begin
            md_d                  = 1'b1;
            shadow_d[JOY_S:JOY_A] = hi;
          end else begin
            md_d                  = 1'b0;
            shadow_d[JOY_S:JOY_A] = 2'b11;
          end
        end
        // Third select-low with all directions low marks a 6-button pad
        StP4: six_d = md_q && (dirs == 4'h0);
        // Frame end: last capture and output update on the same edge
        StP5: begin
          shadow_d[JOY_M:JOY_Z] = six_q ? dirs : 4'hF;
          joy_d                 = shadow_d;
          six_out_d             = six_q;
        end
        default: ;
      endcase
    end
  end

  // Shadow, detection flags and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= JOY_IDLE;
      md_q      <= 1'b0;
      six_q     <= 1'b0;
      joy_q     <= JOY_IDLE;
      six_out_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      md_q      <= md_d;
      six_q     <= six_d;
      joy_q     <= joy_d;
      six_out_q <= six_out_d;
    end
  end

  assign joy_o = joy_q;
  assign six_o = six_out_q;

endmodule

// File: rtl/sega_joy_sequencer.sv
// Select-line phase sequencer shared by both DB9 ports, plus the two port
// capture blocks.
module sega_joy_sequencer
  import sega_joy_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 240,
  parameter int unsigned GAP_CYCLES   = 48000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joy_sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        joy1_six_o,
  output logic        joy2_six_o,
  output logic        frame_o
);

  localparam int unsigned MaxCycles = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);
  localparam logic [CntW-1:0] PhaseLoad = CntW'(PHASE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  phase_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic            last;

  assign last = (cnt_q == '0);

  // Advance phase when the down-counter expires, reloading for the new phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CntW'(1);
    sel_d   = sel_q;
    if (last) begin
      case (state_q)
        StGap:   state_d = StP0;
        StP0:    state_d = StP1;
        StP1:    state_d = StP2;
        StP2:    state_d = StP3;
        StP3:    state_d = StP4;
        StP4:    state_d = StP5;
        default: state_d = StGap;
      endcase
      cnt_d = (state_d == StGap) ? GapLoad : PhaseLoad;
      sel_d = phase_sel(state_d);
    end
  end

  // Phase, counter and registered select line
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= StGap;
      cnt_q   <= GapLoad;
      sel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign joy_sel_o = sel_q;
  // High in the final P5 cycle; port outputs take the new frame on the next edge
  assign frame_o   = last && (state_q == StP5);

  sega_joy_port u_port1 (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .pins_i  (joy1_i),
    .phase_i (state_q),
    .last_i  (last),
    .joy_o   (joy1_o),
    .six_o   (joy1_six_o)
  );

  sega_joy_port u_port2 (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .pins_i  (joy2_i),
    .phase_i (state_q),
    .last_i  (last),
    .joy_o   (joy2_o),
    .six_o   (joy2_six_o)
  );

endmodule

// File: tb/tb_sega_joy_sequencer.sv
// Directed bench for sega_joy_sequencer with behavioural SMS / 3-button /
// 6-button pad models on both ports.
module tb_sega_joy_sequencer;
  import sega_joy_pkg::*;

  localparam int unsigned PC    = 4;
  localparam int unsigned GC    = 16;
  localparam int unsigned FRAME = 6 * PC + GC;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b0;
  logic [5:0]  joy1_i, joy2_i;
  logic        joy_sel_o, joy1_six_o, joy2_six_o, frame_o;
  logic [11:0] joy1_o, joy2_o;

  int n_vec = 0;
  int n_err = 0;

  // Pad configuration: 0 unplugged, 1 SMS, 2 MD 3-button, 3 MD 6-button
  int          mode1 = 0;
  int          mode2 = 0;
  logic [11:0] btn1  = 12'hFFF;
  logic [11:0] btn2  = 12'hFFF;

  // 6-button pad state: count of select falls since a long idle
  int hi_cnt = 0;
  int nlow   = 0;

  sega_joy_sequencer #(
    .PHASE_CYCLES (PC),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy1_i     (joy1_i),
    .joy2_i     (joy2_i),
    .joy_sel_o  (joy_sel_o),
    .joy1_o     (joy1_o),
    .joy2_o     (joy2_o),
    .joy1_six_o (joy1_six_o),
    .joy2_six_o (joy2_six_o),
    .frame_o    (frame_o)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (joy_sel_o) hi_cnt <= hi_cnt + 1;
    else           hi_cnt <= 0;
  end

  always @(negedge joy_sel_o) begin
    nlow <= (hi_cnt > 8) ? 1 : nlow + 1;
  end

  function automatic logic [5:0] pad(int mode, logic [11:0] b, logic sel, int n);
    case (mode)
      1: return {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]};
      2, 3: begin
        if (sel) begin
          if (mode == 3 && n == 3)
            return {b[JOY_C], b[JOY_B], b[JOY_M], b[JOY_X], b[JOY_Y], b[JOY_Z]};
          return {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]};
        end
        if (mode == 3 && n == 3) return {b[JOY_S], b[JOY_A], 4'b0000};
        return {b[JOY_S], b[JOY_A], 2'b00, b[JOY_D], b[JOY_U]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign joy1_i = pad(mode1, btn1, joy_sel_o, nlow);
  assign joy2_i = pad(mode2, btn2, joy_sel_o, nlow);

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Returns at the negedge inside the frame_o cycle, or flags a timeout
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk_sys);
      if (frame_o) seen = 1'b1;
    end
    if (!seen) check_eq("frame_timeout", frame_o, 12'd1);
  endtask

  // One partial frame, one full frame, then step into the first gap cycle
  task automatic settle();
    wait_frame();
    wait_frame();
    @(negedge clk_sys);
  endtask

  // Starts at the first cycle after reset release; checks select and frame_o
  task automatic check_pattern(input int cycles);
    int   idx;
    logic want_sel, want_frame;
    for (int i = 0; i < cycles; i++) begin
      idx        = i % FRAME;
      want_sel   = (idx < GC) ? 1'b1 : (((idx - GC) / PC) % 2 == 1);
      want_frame = (idx == FRAME - 1);
      check_eq("sel_pattern", joy_sel_o, want_sel);
      check_eq("frame_pattern", frame_o, want_frame);
      @(negedge clk_sys);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_sel", joy_sel_o, 12'd1);
    check_eq("rst_joy1", joy1_o, 12'hFFF);
    check_eq("rst_joy2", joy2_o, 12'hFFF);
    check_eq("rst_six1", joy1_six_o, 12'd0);
    check_eq("rst_six2", joy2_six_o, 12'd0);
    check_eq("rst_frame", frame_o, 12'd0);

    // Idle ports: select pattern and frame cadence over two frames
    reset = 1'b0;
    check_pattern(2 * FRAME);
    check_eq("idle_joy1", joy1_o, 12'hFFF);
    check_eq("idle_joy2", joy2_o, 12'hFFF);
    check_eq("idle_six1", joy1_six_o, 12'd0);
    check_eq("idle_six2", joy2_six_o, 12'd0);

    // SMS pad, up + button 1
    mode1 = 1;
    btn1  = 12'hFEE;
    settle();
    check_eq("sms_joy1", joy1_o, 12'hFEE);
    check_eq("sms_six1", joy1_six_o, 12'd0);
    check_eq("sms_joy2", joy2_o, 12'hFFF);

    // 3-button pad, Start + A
    mode1 = 2;
    btn1  = 12'hF3F;
    settle();
    check_eq("md3_joy1", joy1_o, 12'hF3F);
    check_eq("md3_six1", joy1_six_o, 12'd0);

    // 6-button pad on port 2: Mode + Y, then Mode + X, then Start + Up
    mode2 = 3;
    btn2  = 12'h5FF;
    settle();
    check_eq("md6_my_joy2", joy2_o, 12'h5FF);
    check_eq("md6_my_six2", joy2_six_o, 12'd1);
    check_eq("md6_my_joy1", joy1_o, 12'hF3F);
    check_eq("md6_my_six1", joy1_six_o, 12'd0);
    btn2 = 12'h3FF;
    settle();
    check_eq("md6_mx_joy2", joy2_o, 12'h3FF);
    check_eq("md6_mx_six2", joy2_six_o, 12'd1);
    btn2 = 12'hF7E;
    settle();
    check_eq("md6_su_joy2", joy2_o, 12'hF7E);
    check_eq("md6_su_six2", joy2_six_o, 12'd1);

    // Press A at the start of P1: output holds until the frame end edge
    btn1 = 12'hF7F;
    settle();
    check_eq("hold_base", joy1_o, 12'hF7F);
    repeat (GC + PC) @(negedge clk_sys);
    btn1 = 12'hF3F;
    for (int i = GC + PC; i < FRAME; i++) begin
      check_eq("hold_mid_frame", joy1_o, 12'hF7F);
      @(negedge clk_sys);
    end
    check_eq("hold_frame_seen", frame_o, 12'd0);
    check_eq("hold_post_frame", joy1_o, 12'hF3F);

    // Reset in the middle of P3 aborts the frame immediately
    repeat (GC + 3 * PC + 1) @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_sel", joy_sel_o, 12'd1);
    check_eq("mid_rst_joy1", joy1_o, 12'hFFF);
    check_eq("mid_rst_joy2", joy2_o, 12'hFFF);
    check_eq("mid_rst_six2", joy2_six_o, 12'd0);
    check_eq("mid_rst_frame", frame_o, 12'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    check_pattern(FRAME);
    check_eq("post_rst_joy1", joy1_o, 12'hF3F);
    check_eq("post_rst_joy2", joy2_o, 12'hF7E);
    check_eq("post_rst_six2", joy2_six_o, 12'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
